// File: rtl/cla_pkg.sv
// Shared types for the carry-lookahead adder family.
package cla_pkg;

  localparam int unsigned CLA_W = 4;

  typedef logic [CLA_W-1:0] cla_nib_t;

  // Group generate/propagate pair, consumed by higher-level lookahead units.
  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

endpackage

// File: rtl/cla4_lookahead.sv
// Combinational 4-bit lookahead: flat two-level carries plus group G/P.
module cla4_lookahead
  import cla_pkg::*;
(
  input  logic [CLA_W-1:0] p_i,
  input  logic [CLA_W-1:0] g_i,
  input  logic             c0_i,
  output logic [CLA_W-1:0] c_o,   // c_o[k] is carry into bit k+1 (c1..c4)
  output logic             gg_o,
  output logic             gp_o
);

  pg_t grp;

  always_comb begin
    grp   = '0;
    grp.g = g_i[3]
          | (p_i[3] & g_i[2])
          | (p_i[3] & p_i[2] & g_i[1])
          | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
    grp.p = &p_i;

    c_o    = '0;
    c_o[0] = g_i[0] | (p_i[0] & c0_i);
    c_o[1] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c0_i);
    c_o[2] = g_i[2]
           | (p_i[2] & g_i[1])
           | (p_i[2] & p_i[1] & g_i[0])
           | (p_i[2] & p_i[1] & p_i[0] & c0_i);
    c_o[3] = grp.g | (grp.p & c0_i);
  end

  assign gg_o = grp.g;
  assign gp_o = grp.p;

endmodule

// File: rtl/cla4_reg.sv
// Registered 4-bit carry-lookahead slice with 1-cycle latency.
// Define CLA4_OVF_EN to add the registered signed-overflow output V.
module cla4_reg
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in,
  output logic             out_valid,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             G,
`ifdef CLA4_OVF_EN
  output logic             V,
`endif
  output logic             P
);

  if (WIDTH != CLA_W) begin : g_width_check
    $error("cla4_reg: lookahead equations only support WIDTH == 4");
  end

  cla_nib_t p_bits, g_bits, carries, s_d, s_q;
  logic     c_d, g_d, p_d;
  logic     c_q, g_q, p_q, valid_q;

  assign p_bits = A ^ B;
  assign g_bits = A & B;

  cla4_lookahead u_lookahead (
    .p_i  (p_bits),
    .g_i  (g_bits),
    .c0_i (in),
    .c_o  (carries),
    .gg_o (g_d),
    .gp_o (p_d)
  );

  assign s_d = p_bits ^ {carries[2:0], in};
  assign c_d = carries[3];

`ifdef CLA4_OVF_EN
  logic v_d, v_q;
  assign v_d = carries[3] ^ carries[2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= 1'b0;
    end else if (in_valid) begin
      v_q <= v_d;
    end
  end

  assign V = v_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
      g_q     <= 1'b0;
      p_q     <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        s_q <= s_d;
        c_q <= c_d;
        g_q <= g_d;
        p_q <= p_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign S         = s_q;
  assign C         = c_q;
  assign G         = g_q;
  assign P         = p_q;

endmodule

// File: tb/tb_cla4_reg.sv
// Self-checking bench for cla4_reg against an arithmetic reference model.
module tb_cla4_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a, b;
  logic       cin;
  logic       out_valid;
  logic [3:0] s;
  logic       c, g, p;
`ifdef CLA4_OVF_EN
  logic       v;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Expected registered state
  logic [3:0] e_s;
  logic       e_c, e_g, e_p, e_ov, e_v;

  always #5 clk = ~clk;

  cla4_reg #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (a),
    .B         (b),
    .in        (cin),
    .out_valid (out_valid),
    .S         (s),
    .C         (c),
    .G         (g),
`ifdef CLA4_OVF_EN
    .V         (v),
`endif
    .P         (p)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, {7'd0, out_valid}, {7'd0, e_ov});
    chk({tag, ".S"},     {4'd0, s},         {4'd0, e_s});
    chk({tag, ".C"},     {7'd0, c},         {7'd0, e_c});
    chk({tag, ".G"},     {7'd0, g},         {7'd0, e_g});
    chk({tag, ".P"},     {7'd0, p},         {7'd0, e_p});
`ifdef CLA4_OVF_EN
    chk({tag, ".V"},     {7'd0, v},         {7'd0, e_v});
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle and update the model the way a registered adder should behave.
  task automatic op(input logic vld, input logic [3:0] aa, input logic [3:0] bb,
                    input logic ci, input logic rstn = 1'b1);
    int sum, ssum;
    rst_n = rstn; in_valid = vld; a = aa; b = bb; cin = ci;
    step();
    if (!rstn) begin
      e_s = '0; e_c = 0; e_g = 0; e_p = 0; e_v = 0; e_ov = 0;
    end else begin
      e_ov = vld;
      if (vld) begin
        sum  = int'(aa) + int'(bb) + int'(ci);
        ssum = int'($signed(aa)) + int'($signed(bb)) + int'(ci);
        e_s  = sum[3:0];
        e_c  = (sum > 15);
        e_g  = (int'(aa) + int'(bb)) > 15;
        e_p  = ((aa ^ bb) == 4'hF);
        e_v  = (ssum > 7) || (ssum < -8);
      end
    end
  endtask

  initial begin
    e_s = '0; e_c = 0; e_g = 0; e_p = 0; e_v = 0; e_ov = 0;

    // Reset with busy inputs
    op(1'b1, 4'hF, 4'hF, 1'b1, 1'b0);
    op(1'b1, 4'hA, 4'h7, 1'b1, 1'b0);
    check_all("reset");

    op(1'b1, 4'b0011, 4'b0110, 1'b0); check_all("3+6");
    op(1'b1, 4'b1010, 4'b0101, 1'b1); check_all("allprop_c1");
    op(1'b1, 4'b1010, 4'b0101, 1'b0); check_all("allprop_c0");
    op(1'b1, 4'b1100, 4'b0101, 1'b0); check_all("gen_out");
    op(1'b1, 4'b0100, 4'b1001, 1'b0); check_all("4+9");
    op(1'b1, 4'b0000, 4'b0100, 1'b1); check_all("0+4+1");
    op(1'b1, 4'b1000, 4'b0000, 1'b1); check_all("8+0+1");
    op(1'b0, 4'hF, 4'hF, 1'b1);       check_all("hold1");
    op(1'b0, 4'h3, 4'h9, 1'b0);       check_all("hold2");

    // Back-to-back stream, then reset mid-stream
    for (int i = 0; i < 3; i++) begin
      op(1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
      check_all("stream");
    end
    op(1'b1, 4'hF, 4'h1, 1'b1, 1'b0); check_all("mid_reset");

`ifdef CLA4_OVF_EN
    op(1'b1, 4'b0111, 4'b0001, 1'b0); check_all("ovf");
    chk("ovf_V_direct", {7'd0, v}, 8'd1);
`endif

    // Exhaustive sweep
    for (int i = 0; i < 512; i++) begin
      op(1'b1, 4'(i >> 5), 4'(i >> 1), 1'(i));
      check_all("sweep");
    end

    // Random traffic with gaps and occasional resets
    for (int i = 0; i < 200; i++) begin
      op(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 1'($urandom),
         1'($urandom_range(0, 19) != 0));
      check_all("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
